// File: rtl/babbage_inverse_engine_pkg.sv
// Shared widths, difference-engine seed values and FSM encoding for the
// Babbage inverse engine and its difference stepper.
package babbage_pkg;

  localparam int unsigned ACC_W    = 20;
  localparam int unsigned N_W      = 6;
  localparam int unsigned TARGET_W = 16;
  localparam int unsigned F_OUT_W  = 17;

  // Seeds for f(n) = n^3 + 2n^2 + 2n + 1 at n = 0
  localparam logic [ACC_W-1:0] F0    = 20'd1;
  localparam logic [ACC_W-1:0] D1_0  = 20'd5;
  localparam logic [ACC_W-1:0] D2_0  = 20'd10;
  localparam logic [ACC_W-1:0] D3    = 20'd6;
  localparam logic [N_W-1:0]   N_MAX = 6'd40;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic [ACC_W-1:0] widen_target(input logic [TARGET_W-1:0] t);
    return {{(ACC_W-TARGET_W){1'b0}}, t};
  endfunction

endpackage

// File: rtl/babbage_inverse_engine_if.sv
// Request/result bundle for the Babbage inverse engine.
// exact_o exists only when BABBAGE_INV_EXACT_EN is defined.
interface babbage_inverse_engine_if;
  import babbage_pkg::*;

  logic                start_i;
  logic [TARGET_W-1:0] target_i;
  logic                ready_o;
  logic                done_o;
  logic [N_W-1:0]      n_o;
  logic [F_OUT_W-1:0]  f_of_n_o;
`ifdef BABBAGE_INV_EXACT_EN
  logic                exact_o;

  modport master (
    output start_i, target_i,
    input  ready_o, done_o, n_o, f_of_n_o, exact_o
  );
  modport slave (
    input  start_i, target_i,
    output ready_o, done_o, n_o, f_of_n_o, exact_o
  );
`else
  modport master (
    output start_i, target_i,
    input  ready_o, done_o, n_o, f_of_n_o
  );
  modport slave (
    input  start_i, target_i,
    output ready_o, done_o, n_o, f_of_n_o
  );
`endif
endinterface

// File: rtl/babbage_inverse_engine_diff_stepper.sv
// Finite-difference chain stepping f(n) = n^3 + 2n^2 + 2n + 1 one n per
// clock using additions only; shared with the forward engine.
module babbage_diff_stepper
  import babbage_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             step_i,
  output logic [ACC_W-1:0] f_o,
  output logic [N_W-1:0]   n_o
);

  logic [ACC_W-1:0] f_q, f_d;
  logic [ACC_W-1:0] d1_q, d1_d;
  logic [ACC_W-1:0] d2_q, d2_d;
  logic [N_W-1:0]   n_q, n_d;

  // All differences advance from their old values so the chain stays aligned
  always_comb begin
    f_d  = f_q;
    d1_d = d1_q;
    d2_d = d2_q;
    n_d  = n_q;
    if (load_i) begin
      f_d  = F0;
      d1_d = D1_0;
      d2_d = D2_0;
      n_d  = '0;
    end else if (step_i) begin
      f_d  = f_q + d1_q;
      d1_d = d1_q + d2_q;
      d2_d = d2_q + D3;
      n_d  = n_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      f_q  <= '0;
      d1_q <= '0;
      d2_q <= '0;
      n_q  <= '0;
    end else begin
      f_q  <= f_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      n_q  <= n_d;
    end
  end

  assign f_o = f_q;
  assign n_o = n_q;

endmodule

// File: rtl/babbage_inverse_engine.sv
// Babbage inverse engine: finds the smallest n with f(n) >= target.
// Optional exact-match flag enabled by BABBAGE_INV_EXACT_EN.
module babbage_inverse_engine
  import babbage_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     reset_i,
  babbage_inverse_engine_if.slave  bus
);

  state_e              state_q;
  logic [TARGET_W-1:0] target_q;
  logic                ready_q;
  logic                done_q;
  logic [N_W-1:0]      n_out_q;
  logic [F_OUT_W-1:0]  f_out_q;
`ifdef BABBAGE_INV_EXACT_EN
  logic                exact_q;
`endif

  logic [ACC_W-1:0] step_f;
  logic [N_W-1:0]   step_n;
  logic             hit;
  logic             load;
  logic             step;

  assign hit  = (step_f >= widen_target(target_q));
  assign load = (state_q == IDLE) && bus.start_i;
  assign step = (state_q == SEARCH) && !hit;

  babbage_diff_stepper u_stepper (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load),
    .step_i  (step),
    .f_o     (step_f),
    .n_o     (step_n)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      target_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      n_out_q  <= '0;
      f_out_q  <= '0;
`ifdef BABBAGE_INV_EXACT_EN
      exact_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start_i) begin
            target_q <= bus.target_i;
            ready_q  <= 1'b0;
            state_q  <= SEARCH;
          end
        end
        SEARCH: begin
          if (hit) begin
            n_out_q <= step_n;
            f_out_q <= step_f[F_OUT_W-1:0];
`ifdef BABBAGE_INV_EXACT_EN
            exact_q <= (step_f == widen_target(target_q));
`endif
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.done_o   = done_q;
  assign bus.n_o      = n_out_q;
  assign bus.f_of_n_o = f_out_q;
`ifdef BABBAGE_INV_EXACT_EN
  assign bus.exact_o  = exact_q;
`endif

endmodule

// File: tb/tb_babbage_inverse_engine.sv
// Scoreboard bench for babbage_inverse_engine: stimulus pushes hand-computed
// results into a FIFO, a negedge monitor pops and compares on each done_o.
module tb_babbage_inverse_engine;
  import babbage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  babbage_inverse_engine_if bus ();

  babbage_inverse_engine dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  // Expected-result FIFO: written only by stimulus, read only by the monitor
  localparam int unsigned SB_DEPTH = 32;
  logic [5:0]  sb_n     [SB_DEPTH];
  logic [16:0] sb_f     [SB_DEPTH];
  logic        sb_exact [SB_DEPTH];
  int unsigned wr_idx = 0;
  int unsigned rd_idx = 0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accept_cyc = 0;
  logic prev_done = 1'b0;

  // Requests from stimulus to the monitor, one writer each side
  int chk_req = 0;
  int chk_ack = 0;
  int to_req  = 0;
  int to_ack  = 0;
  logic fin_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && bus.start_i && bus.ready_o)
      accept_cyc = cyc + 1;

    if (!reset && dut.state_q == SEARCH) begin
      total++;
      if (dut.step_n > N_MAX) begin
        bad++;
        $display("FAIL n_bound: n=%0d required <= %0d", dut.step_n, N_MAX);
      end
    end

    if (to_req != to_ack) begin
      total++;
      bad++;
      $display("FAIL wait_ready: timed out (%0d) required ready_o=1", to_req);
      to_ack = to_req;
    end

    if (chk_req != chk_ack) begin
      chk_ack = chk_req;
      total += 4;
      if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL idle_ready: got %b required 1", bus.ready_o); end
      if (bus.done_o !== 1'b0) begin bad++; $display("FAIL idle_done: got %b required 0", bus.done_o); end
      if (bus.n_o !== 6'd0) begin bad++; $display("FAIL idle_n: got %0d required 0", bus.n_o); end
      if (bus.f_of_n_o !== 17'd0) begin bad++; $display("FAIL idle_f: got %0d required 0", bus.f_of_n_o); end
`ifdef BABBAGE_INV_EXACT_EN
      total++;
      if (bus.exact_o !== 1'b0) begin bad++; $display("FAIL idle_exact: got %b required 0", bus.exact_o); end
`endif
    end

    if (bus.done_o === 1'b1) begin
      total++;
      if (rd_idx == wr_idx) begin
        bad++;
        $display("FAIL unexpected_done: got done_o with n=%0d, required no pending search", bus.n_o);
      end else begin
        automatic int unsigned k = rd_idx % SB_DEPTH;
        automatic int lat = cyc - accept_cyc;
        rd_idx++;
        total += 3;
        if (bus.n_o !== sb_n[k]) begin bad++; $display("FAIL result_n: got %0d required %0d", bus.n_o, sb_n[k]); end
        if (bus.f_of_n_o !== sb_f[k]) begin bad++; $display("FAIL result_f: got %0d required %0d", bus.f_of_n_o, sb_f[k]); end
        if (lat != int'(sb_n[k]) + 1) begin bad++; $display("FAIL latency: got %0d edges required %0d", lat, int'(sb_n[k]) + 1); end
        if (prev_done !== 1'b0) begin bad++; $display("FAIL done_width: done_o high on consecutive cycles"); end
`ifdef BABBAGE_INV_EXACT_EN
        total++;
        if (bus.exact_o !== sb_exact[k]) begin bad++; $display("FAIL result_exact: got %b required %b", bus.exact_o, sb_exact[k]); end
`endif
      end
    end
    prev_done = bus.done_o;

    if (fin_req) begin
      total++;
      if (rd_idx != wr_idx) begin
        bad++;
        $display("FAIL pending: got %0d unanswered searches required 0", wr_idx - rd_idx);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o === 1'b1) return;
    end
    to_req++;
  endtask

  task automatic issue(input logic [15:0] t);
    wait_ready();
    bus.start_i  = 1'b1;
    bus.target_i = t;
    @(posedge clk); #1;
    bus.start_i  = 1'b0;
  endtask

  task automatic search(input logic [15:0] t, input logic [5:0] en,
                        input logic [16:0] ef, input logic ex);
    sb_n[wr_idx % SB_DEPTH]     = en;
    sb_f[wr_idx % SB_DEPTH]     = ef;
    sb_exact[wr_idx % SB_DEPTH] = ex;
    wr_idx++;
    issue(t);
  endtask

  initial begin
    reset        = 1'b1;
    bus.start_i  = 1'b0;
    bus.target_i = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_req++;
    @(posedge clk); #1;

    search(16'd1,     6'd0,  17'd1,     1'b1);
    search(16'd0,     6'd0,  17'd1,     1'b0);
    search(16'd6,     6'd1,  17'd6,     1'b1);
    search(16'd7,     6'd2,  17'd21,    1'b0);
    search(16'd21,    6'd2,  17'd21,    1'b1);
    search(16'd22,    6'd3,  17'd52,    1'b0);
    search(16'd62440, 6'd39, 17'd62440, 1'b1);
    search(16'd65535, 6'd40, 17'd67281, 1'b0);

    // Starts during SEARCH with another target must be ignored
    search(16'd62440, 6'd39, 17'd62440, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bus.start_i  = 1'b1;
      bus.target_i = 16'd100 + 16'(i);
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;

    // Reset while the search sits at n = 10 (outputs hold n=39 beforehand)
    issue(16'd65535);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_req++;
    @(posedge clk); #1;

    search(16'd52, 6'd3, 17'd52, 1'b1);
    wait_ready();
    repeat (3) @(posedge clk);
    #1 fin_req = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
